gpio_debounce: RTL and testbench
================================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter CH, default 4, number of raw input channels.
REQ-002 SHALL have parameter STABLE_CNT, default 50000, cycles of stable level required to accept a change (1 ms at 50 MHz); legal range 1..65535.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset_  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port raw_in  input  CH  asynchronous switch/button levels from pins.
REQ-006 SHALL have port clean_out  output  CH  debounced levels; drives gpio_in of the GPIO block.
REQ-007 SHALL have port cs_  input  1  bus chip select, active-low.
REQ-008 SHALL have port as_  input  1  bus address strobe, active-low.
REQ-009 SHALL have port rw  input  1  bus direction, READ/WRITE per stddef.h.
REQ-010 SHALL have port addr  input  30  word address; only addr[1:0] decoded.
REQ-011 SHALL have port wr_data  input  32  write data.
REQ-012 SHALL have port rd_data  output  32  read data.
REQ-013 SHALL have port rdy_  output  1  bus ready, active-low.
REQ-014 SHALL have port irq  output  1  interrupt request, active-high.

Function
REQ-015 Each raw_in bit SHALL pass a 2-flop synchronizer; its output is sync[i].
REQ-016 Per channel, a 16-bit counter SHALL clear whenever sync[i]==clean_out[i] and increment whenever they differ.
REQ-017 When they differ and counter==STABLE_CNT-1, at the next edge clean_out[i]<=sync[i] and counter<=0.
REQ-018 A raw change held stable SHALL appear on clean_out exactly 2+STABLE_CNT edges after the first edge sampling it; any glitch shorter than STABLE_CNT cycles after sync SHALL not change clean_out.
REQ-019 Register map (addr[1:0]): 0 STATUS = clean_out (RO); 1 PEND (W1C); 2 RISE_EN (RW); 3 FALL_EN (RW); unused bits read 0.
REQ-020 PEND[i] SHALL set on the edge after clean_out[i] rises with RISE_EN[i]=1 or falls with FALL_EN[i]=1.
REQ-021 Write to PEND SHALL clear bits written 1; a set event in the same cycle SHALL win (bit stays 1).
REQ-022 irq SHALL be registered |(PEND), asserted one edge after any PEND bit is 1.
REQ-023 rdy_ SHALL be ENABLE_ exactly one cycle after any cycle with cs_ and as_ both ENABLE_, else DISABLE_.
REQ-024 On a read cycle rd_data SHALL load the selected register at the next edge; otherwise rd_data SHALL load 0.
REQ-025 Writes to STATUS SHALL be ignored; writes use wr_data[CH-1:0].
REQ-026 Changing RISE_EN/FALL_EN SHALL not alter existing PEND bits.

Reset
REQ-027 On reset_ low: sync flops, counters, clean_out, PEND, RISE_EN, FALL_EN, irq, rd_data cleared to 0; rdy_ = DISABLE_.
REQ-028 Reset mid-count SHALL discard the count; after release clean_out restarts from 0, so a raw_in held 1 reappears after 2+STABLE_CNT edges and, if RISE_EN=1 is rewritten first, sets PEND.

Structure
REQ-029 Register addresses, widths, and STABLE_CNT default SHALL live in shared header gpio_debounce.h; ENABLE_/READ/WRITE/LOW come from stddef.h.
REQ-030 Per-channel synchronizer+counter SHALL be sub-module debounce_ch, instantiated CH times by generate.

Verification (STABLE_CNT=4)
REQ-031 raw_in[0] 0->1 held -> clean_out[0]=1 at edge 6; with RISE_EN=1, PEND=0x1 at edge 7, irq=1 at edge 8.
REQ-032 raw_in[1] 3-cycle high pulse -> clean_out stays 0, PEND stays 0, irq stays 0.
REQ-033 PEND=0x1, write 0x1 to addr 1 in same cycle as a new falling event on ch0 with FALL_EN=1 -> PEND stays 0x1.
REQ-034 Read addr 0 with clean_out=0xA -> rdy_=0 and rd_data=0x0000000A one cycle later, both return to 1/0 the following cycle.
REQ-035 Assert reset_ at count 2 of a pending change on ch2 -> all outputs 0, rdy_=1; after release, change takes full 2+4 edges.

Source files
------------

// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg: shared constants, bus levels and register map for the debouncer
package gpio_debounce_pkg;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam int   CNT_W          = 16;
    localparam int   DATA_W         = 32;
    localparam int   ADDR_W         = 30;
    localparam int   STABLE_CNT_DEF = 50000;
    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_PEND    = 2'd1,
        REG_RISE_EN = 2'd2,
        REG_FALL_EN = 2'd3
    } reg_addr_e;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel of 2-flop synchronizer plus stable-level counter
// Ports: clk, reset_ (async active-low), raw (pin level), clean (debounced level)
module debounce_ch
    import gpio_debounce_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic clk,
    input  logic reset_,
    input  logic raw,
    output logic clean
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
    logic s1, s2;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == clean) cnt <= '0;
            else if (cnt == LAST) begin
                clean <= s2;
                cnt   <= '0;
            end else cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce: CH-channel switch debouncer with edge-pending interrupt and register bus
// Ports: clk, reset_ (async active-low), raw_in/clean_out (pin levels in, debounced out),
//        cs_/as_/rw/addr/wr_data/rd_data/rdy_ (register bus), irq (any pending edge)
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int CH         = 4,
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [CH-1:0]     raw_in,
    output logic [CH-1:0]     clean_out,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              irq
);
    logic [CH-1:0] clean_q, pend, rise_en, fall_en, set_ev, clr;
    logic [DATA_W-1:0] rd_sel;
    logic bus, wr, rd;
    reg_addr_e a;
    logic unused_bits;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_ch #(.STABLE_CNT(STABLE_CNT)) u_ch (
            .clk   (clk),
            .reset_(reset_),
            .raw   (raw_in[i]),
            .clean (clean_out[i])
        );
    end

    assign unused_bits = ^{addr[ADDR_W-1:2], wr_data};

    always_comb begin
        a      = reg_addr_e'(addr[1:0]);
        bus    = (cs_ == ENABLE_) && (as_ == ENABLE_);
        wr     = bus && (rw == WRITE);
        rd     = bus && (rw == READ);
        set_ev = (clean_out & ~clean_q & rise_en) | (~clean_out & clean_q & fall_en);
        clr    = (wr && a == REG_PEND) ? wr_data[CH-1:0] : '0;
        rd_sel = a == REG_STATUS  ? DATA_W'(clean_out) :
                 a == REG_PEND    ? DATA_W'(pend) :
                 a == REG_RISE_EN ? DATA_W'(rise_en) : DATA_W'(fall_en);
    end

    // set_ev is OR-ed after the clear so a same-cycle edge keeps its pending bit
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            clean_q <= '0;
            pend    <= '0;
            rise_en <= '0;
            fall_en <= '0;
            irq     <= 1'b0;
            rd_data <= '0;
            rdy_    <= DISABLE_;
        end else begin
            clean_q <= clean_out;
            pend    <= (pend & ~clr) | set_ev;
            irq     <= |pend;
            if (wr && a == REG_RISE_EN) rise_en <= wr_data[CH-1:0];
            if (wr && a == REG_FALL_EN) fall_en <= wr_data[CH-1:0];
            rdy_    <= bus ? ENABLE_ : DISABLE_;
            rd_data <= rd ? rd_sel : '0;
        end
    end
endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed scoreboard bench for gpio_debounce with STABLE_CNT=4
module tb_gpio_debounce;
    import gpio_debounce_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [3:0]  raw_in = '0;
    logic [3:0]  clean_out;
    logic        cs_ = 1'b1, as_ = 1'b1, rw = READ;
    logic [29:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rdy_, irq;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic chk_idle = 1'b0;

    gpio_debounce #(.CH(4), .STABLE_CNT(4)) dut (
        .clk(clk), .reset_(reset_), .raw_in(raw_in), .clean_out(clean_out),
        .cs_(cs_), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .rdy_(rdy_), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 cs_ = 1'b0; as_ = 1'b0; rw = WRITE; addr = 30'(a); wr_data = d;
        exp_q.push_back('{$sformatf("wr_ack_a%0d", a), 32'h0});
        @(posedge clk);
        #1 cs_ = 1'b1; as_ = 1'b1; rw = READ; wr_data = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(posedge clk);
        #1 cs_ = 1'b0; as_ = 1'b0; rw = READ; addr = 30'(a);
        exp_q.push_back('{name, exp});
        @(posedge clk);
        #1 cs_ = 1'b1; as_ = 1'b1;
        @(negedge clk);
        check({"rdy_latency_", name}, 32'(rdy_), 32'(ENABLE_));
    endtask

    // Monitor: every bus acknowledge consumes one expected response
    initial forever begin
        @(negedge clk);
        if (chk_idle) begin
            check("rdy_release", {rd_data[30:0], rdy_}, 32'(DISABLE_));
            chk_idle = 1'b0;
        end
        if (reset_ && rdy_ == ENABLE_) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 32'(rdy_), 32'(DISABLE_));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, rd_data, e.data);
            end
            chk_idle = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_clean", 32'(clean_out), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_rdy", 32'(rdy_), 32'(DISABLE_));
        check("reset_rd_data", rd_data, 32'h0);
        @(posedge clk);
        #1 reset_ = 1'b1;

        bus_write(2, 32'h1);
        bus_read(2, 32'h1, "rise_en_rb");
        bus_read(3, 32'h0, "fall_en_rb");
        bus_read(1, 32'h0, "pend_init");

        // ch0 rise: clean at edge 6, PEND at 7, irq at 8
        @(posedge clk);
        #1 raw_in[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rise_edge%0d", k), 32'(clean_out[0]), 32'(k >= 6));
        end
        @(posedge clk);
        @(negedge clk);
        check("irq_edge7", 32'(irq), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("irq_edge8", 32'(irq), 32'h1);
        bus_read(1, 32'h1, "pend_rise0");
        bus_read(0, 32'h1, "status_ch0");

        bus_write(1, 32'h1);
        bus_read(1, 32'h0, "pend_w1c");
        check("irq_cleared", 32'(irq), 32'h0);

        // 3-cycle glitch on ch1 must be filtered
        bus_write(2, 32'h3);
        @(posedge clk);
        #1 raw_in[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 raw_in[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("glitch_c%0d", k), {30'h0, clean_out[1], irq}, 32'h0);
        end
        bus_read(1, 32'h0, "pend_glitch");

        // Arm PEND[0] via a rise, then clear it in the same cycle as a fall event
        @(posedge clk);
        #1 raw_in[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1 raw_in[0] = 1'b1;
        repeat (8) @(posedge clk);
        bus_read(1, 32'h1, "pend_armed");
        bus_write(3, 32'h1);
        @(posedge clk);
        #1 raw_in[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("fall_edge5", 32'(clean_out[0]), 32'h1);
        bus_write(1, 32'h1);
        @(negedge clk);
        check("fall_edge7", 32'(clean_out[0]), 32'h0);
        bus_read(1, 32'h1, "pend_set_wins");
        check("irq_set_wins", 32'(irq), 32'h1);
        bus_write(1, 32'h1);
        bus_read(1, 32'h0, "pend_w1c2");

        // clean_out = 0xA; ch1 rise pends, ch3 rise is masked
        @(posedge clk);
        #1 raw_in = 4'b1010;
        repeat (10) @(posedge clk);
        bus_read(0, 32'hA, "status_0xA");
        bus_read(1, 32'h2, "pend_0xA");
        bus_write(2, 32'h0);
        bus_write(3, 32'h0);
        bus_read(1, 32'h2, "pend_kept");
        bus_read(2, 32'h0, "rise_en_cleared");

        // Reset at count 2 of a pending ch2 change
        @(posedge clk);
        #1 raw_in[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset_ = 1'b0;
        #1;
        check("mid_reset_clean", 32'(clean_out), 32'h0);
        check("mid_reset_irq", 32'(irq), 32'h0);
        check("mid_reset_rdy", 32'(rdy_), 32'(DISABLE_));
        check("mid_reset_rd_data", rd_data, 32'h0);
        @(posedge clk);
        #1 reset_ = 1'b1;
        bus_write(2, 32'h4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_reset_edge5", 32'(clean_out), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("post_reset_edge6", 32'(clean_out), 32'hE);
        @(posedge clk);
        @(negedge clk);
        check("post_reset_irq7", 32'(irq), 32'h0);
        bus_read(1, 32'h4, "pend_post_reset");
        bus_read(2, 32'h4, "rise_en_post_reset");

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
